board_io_ctrl: RTL and testbench



---
 rtl/board_io_ctrl_if.sv | 44 ++++
 rtl/board_io_ctrl.sv | 116 +++++++++++
 tb/tb_board_io_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_io_ctrl_if.sv
// board_io_ctrl_if
// GPIO-side bundle between board_io_ctrl and the core.
// The core-facing master drives the interrupt controls and LED requests, and
// it reads back the debounced inputs, the edge pulses and the interrupt state.
// The slave modport is the view used by board_io_ctrl itself.
//   in_deb_o       debounced stable values, {btn, sw}
//   in_rise_o      one-cycle pulse on a debounced 0->1 transition
//   in_fall_o      one-cycle pulse on a debounced 1->0 transition
//   irq_rise_en_i  per-input rise interrupt enable
//   irq_fall_en_i  per-input fall interrupt enable
//   irq_clr_i      write-1-to-clear for pending bits, sampled every cycle
//   irq_pending_o  latched pending bits
//   irq_o          OR of all pending bits
//   led_i          LED on/off request
//   led_duty_i     global LED brightness duty
interface board_io_ctrl_if #(
  parameter int N_SW  = 8,
  parameter int N_BTN = 5,
  parameter int N_LED = 8,
  parameter int PWM_W = 8
);
  localparam int N_IN = N_SW + N_BTN;

  logic [N_IN-1:0]  in_deb_o;
  logic [N_IN-1:0]  in_rise_o;
  logic [N_IN-1:0]  in_fall_o;
  logic [N_IN-1:0]  irq_rise_en_i;
  logic [N_IN-1:0]  irq_fall_en_i;
  logic [N_IN-1:0]  irq_clr_i;
  logic [N_IN-1:0]  irq_pending_o;
  logic             irq_o;
  logic [N_LED-1:0] led_i;
  logic [PWM_W-1:0] led_duty_i;

  modport master (
    input  in_deb_o, in_rise_o, in_fall_o, irq_pending_o, irq_o,
    output irq_rise_en_i, irq_fall_en_i, irq_clr_i, led_i, led_duty_i
  );

  modport slave (
    output in_deb_o, in_rise_o, in_fall_o, irq_pending_o, irq_o,
    input  irq_rise_en_i, irq_fall_en_i, irq_clr_i, led_i, led_duty_i
  );
endinterface

// File: rtl/board_io_ctrl.sv
// board_io_ctrl
// Board glue between raw FPGA pins and the SoC GPIO bus. Switches and buttons
// are synchronised, debounced, turned into rise/fall pulses and a maskable
// latched interrupt. The LEDs are registered and gated by a global PWM
// brightness.
//   clk    system clock, all state on the rising edge
//   rst    synchronous active-high reset
//   sw_i   raw asynchronous switch pins
//   btn_i  raw asynchronous button pins
//   led_o  LED pin drive
//   gpio   core-side bundle (debounced inputs, edges, interrupt, LED control)
// Inputs are packed {btn, sw}: switches in the low bits, buttons above.
module board_io_ctrl #(
  parameter int N_SW            = 8,
  parameter int N_BTN           = 5,
  parameter int N_LED           = 8,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int PWM_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  sw_i,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_LED-1:0] led_o,
  board_io_ctrl_if.slave   gpio
);
  localparam int N_IN = N_SW + N_BTN;
  // A one-cycle debounce still needs a one-bit counter to exist.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0]  sync1;
  logic [N_IN-1:0]  sync2;
  logic [N_IN-1:0]  stable;
  logic [N_IN-1:0]  stable_q;
  logic [CNT_W-1:0] cnt [N_IN];
  logic [N_IN-1:0]  rise;
  logic [N_IN-1:0]  fall;
  logic [N_IN-1:0]  set_vec;
  logic [N_IN-1:0]  pending;
  logic [N_LED-1:0] led_q;
  logic [PWM_W-1:0] pwm_cnt;
  logic             pwm_on;
  logic             pwm_on_q;

  // Two-flop synchroniser, then a per-bit debounce counter. The counter only
  // runs while the synchronised value disagrees with the stable one, so any
  // single agreeing cycle throws the partial count away.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < N_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= {btn_i, sw_i};
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < N_IN; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Edge pulses come from registered state only, so they last exactly the
  // cycle after the stable value moves.
  assign rise = stable & ~stable_q;
  assign fall = ~stable & stable_q;
  assign set_vec = (rise & gpio.irq_rise_en_i) | (fall & gpio.irq_fall_en_i);

  // Pending bits: the set term is OR-ed in after the clear, so a new event
  // in the same cycle as a clear is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~gpio.irq_clr_i) | set_vec;
    end
  end

  assign gpio.in_deb_o      = stable;
  assign gpio.in_rise_o     = rise;
  assign gpio.in_fall_o     = fall;
  assign gpio.irq_pending_o = pending;
  assign gpio.irq_o         = |pending;

  // All-ones duty is forced fully on; otherwise the compare would leave one
  // dark cycle per period.
  assign pwm_on = (&gpio.led_duty_i) | (pwm_cnt < gpio.led_duty_i);

  // LED request and PWM gate are both registered so that the pins never
  // follow a core-side input combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q    <= '0;
      pwm_cnt  <= '0;
      pwm_on_q <= 1'b0;
    end else begin
      led_q    <= gpio.led_i;
      pwm_cnt  <= pwm_cnt + 1'b1;
      pwm_on_q <= pwm_on;
    end
  end

  assign led_o = led_q & {N_LED{pwm_on_q}};
endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl
// Self-checking bench for board_io_ctrl with DEBOUNCE_CYCLES=4 and PWM_W=4.
// A behavioural model tracks every cycle. It treats debounce as "the last
// DEBOUNCE_CYCLES synchronised samples all oppose the stable value" and it
// treats PWM as a phase counted from reset. Hand-written sequences and an LED
// table cover the multi-cycle corner cases, and a random phase follows them.
module tb_board_io_ctrl;
  localparam int N_SW   = 8;
  localparam int N_BTN  = 5;
  localparam int N_LED  = 8;
  localparam int DEB    = 4;
  localparam int PWM_W  = 4;
  localparam int N_IN   = N_SW + N_BTN;
  localparam int PERIOD = 1 << PWM_W;

  logic             clk;
  logic             rst;
  logic [N_SW-1:0]  sw_i;
  logic [N_BTN-1:0] btn_i;
  logic [N_LED-1:0] led_o;
  logic [N_IN-1:0]  raw_in;

  board_io_ctrl_if #(.N_SW(N_SW), .N_BTN(N_BTN), .N_LED(N_LED), .PWM_W(PWM_W)) gpio ();

  board_io_ctrl #(
    .N_SW(N_SW), .N_BTN(N_BTN), .N_LED(N_LED),
    .DEBOUNCE_CYCLES(DEB), .PWM_W(PWM_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_i(sw_i),
    .btn_i(btn_i),
    .led_o(led_o),
    .gpio(gpio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  // Reference model state
  logic [N_IN-1:0]  m_delay1 = '0;
  logic [N_IN-1:0]  m_delay2 = '0;
  logic [N_IN-1:0]  m_hist[$];
  logic [N_IN-1:0]  m_stable = '0;
  logic [N_IN-1:0]  m_stable_q = '0;
  logic [N_IN-1:0]  m_pending = '0;
  logic [N_LED-1:0] m_led_q = '0;
  logic             m_pwm_on_q = 1'b0;
  int               m_phase = 0;

  typedef struct {
    logic [N_LED-1:0] led;
    logic [PWM_W-1:0] duty;
    int               exp_on;
  } led_vec_t;
  led_vec_t led_table[5];

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic apply_stimulus();
    sw_i  = raw_in[N_SW-1:0];
    btn_i = raw_in[N_IN-1:N_SW];
  endtask

  // Model advance at a rising edge, from the pre-edge view of everything.
  task automatic model_step();
    logic [N_IN-1:0] pre_rise;
    logic [N_IN-1:0] pre_fall;
    bit              oppose;
    if (rst) begin
      m_delay1 = '0; m_delay2 = '0; m_hist.delete();
      m_stable = '0; m_stable_q = '0; m_pending = '0;
      m_led_q = '0; m_pwm_on_q = 1'b0; m_phase = 0;
    end else begin
      pre_rise = m_stable & ~m_stable_q;
      pre_fall = ~m_stable & m_stable_q;
      m_pending = (m_pending & ~gpio.irq_clr_i) |
                  (pre_rise & gpio.irq_rise_en_i) | (pre_fall & gpio.irq_fall_en_i);
      m_hist.push_back(m_delay2);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      m_stable_q = m_stable;
      if (m_hist.size() == DEB) begin
        for (int b = 0; b < N_IN; b++) begin
          oppose = 1;
          foreach (m_hist[j]) if (m_hist[j][b] == m_stable[b]) oppose = 0;
          if (oppose) m_stable[b] = ~m_stable[b];
        end
      end
      m_delay2 = m_delay1;
      m_delay1 = {btn_i, sw_i};
      m_pwm_on_q = (gpio.led_duty_i == {PWM_W{1'b1}}) || (m_phase < int'(gpio.led_duty_i));
      m_phase = (m_phase + 1) % PERIOD;
      m_led_q = gpio.led_i;
    end
  endtask

  task automatic compare_model();
    check_output("model_deb",  32'(gpio.in_deb_o),  32'(m_stable));
    check_output("model_rise", 32'(gpio.in_rise_o), 32'(m_stable & ~m_stable_q));
    check_output("model_fall", 32'(gpio.in_fall_o), 32'(~m_stable & m_stable_q));
    check_output("model_pend", 32'(gpio.irq_pending_o), 32'(m_pending));
    check_output("model_irq",  32'(gpio.irq_o), 32'(|m_pending));
    check_output("model_led",  32'(led_o), 32'(m_led_q & {N_LED{m_pwm_on_q}}));
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (chk_on) compare_model();
  endtask

  initial begin
    bit              found;
    bit              bad_deb;
    bit              bad_edge;
    bit              irq_seen;
    int              fall_at;
    int              pend_at;
    int              on_cnt;
    int              bad_cnt;
    logic [N_IN-1:0] rise_seen;
    logic [N_IN-1:0] fall_seen;

    led_table[0] = '{led: 8'hA5, duty: 4'd4,  exp_on: 4};
    led_table[1] = '{led: 8'hA5, duty: 4'd0,  exp_on: 0};
    led_table[2] = '{led: 8'hA5, duty: 4'hF,  exp_on: 16};
    led_table[3] = '{led: 8'h3C, duty: 4'd1,  exp_on: 1};
    led_table[4] = '{led: 8'hFF, duty: 4'd14, exp_on: 14};

    rst = 1'b1;
    raw_in = '0;
    apply_stimulus();
    gpio.irq_rise_en_i = '0;
    gpio.irq_fall_en_i = '0;
    gpio.irq_clr_i     = '0;
    gpio.led_i         = 8'hA5;
    gpio.led_duty_i    = 4'hF;
    @(negedge clk);
    step_cycle();
    chk_on = 1;
    step_cycle();
    check_output("reset_deb",  32'(gpio.in_deb_o), 32'd0);
    check_output("reset_pend", 32'(gpio.irq_pending_o), 32'd0);
    check_output("reset_irq",  32'(gpio.irq_o), 32'd0);
    check_output("reset_led",  32'(led_o), 32'd0);
    rst = 1'b0;
    gpio.led_i = '0;
    repeat (3) step_cycle();

    // Debounce accept on sw[0]
    raw_in[0] = 1'b1;
    apply_stimulus();
    for (int k = 1; k <= 9; k++) begin
      step_cycle();
      check_output("accept_deb",  32'(gpio.in_deb_o[0]),  32'(k >= DEB + 2));
      check_output("accept_rise", 32'(gpio.in_rise_o[0]), 32'(k == DEB + 2));
      check_output("accept_fall", 32'(gpio.in_fall_o),    32'd0);
    end

    // Glitch reject on btn[2]: one 3-cycle pulse, then three separated by 1 low
    bad_deb = 0;
    bad_edge = 0;
    for (int p = 0; p < 4; p++) begin
      raw_in[N_SW+2] = 1'b1;
      apply_stimulus();
      for (int c = 0; c < 3; c++) begin
        step_cycle();
        bad_deb  |= gpio.in_deb_o[N_SW+2];
        bad_edge |= gpio.in_rise_o[N_SW+2] | gpio.in_fall_o[N_SW+2];
      end
      raw_in[N_SW+2] = 1'b0;
      apply_stimulus();
      for (int c = 0; c < ((p == 0) ? 6 : 1); c++) begin
        step_cycle();
        bad_deb  |= gpio.in_deb_o[N_SW+2];
        bad_edge |= gpio.in_rise_o[N_SW+2] | gpio.in_fall_o[N_SW+2];
      end
    end
    for (int c = 0; c < 8; c++) begin
      step_cycle();
      bad_deb  |= gpio.in_deb_o[N_SW+2];
      bad_edge |= gpio.in_rise_o[N_SW+2] | gpio.in_fall_o[N_SW+2];
    end
    check_output("glitch_deb",  32'(bad_deb),  32'd0);
    check_output("glitch_edge", 32'(bad_edge), 32'd0);

    // Interrupt on button 1 release
    gpio.irq_fall_en_i[N_SW+1] = 1'b1;
    raw_in[N_SW+1] = 1'b1;
    apply_stimulus();
    repeat (10) step_cycle();
    check_output("press_deb",  32'(gpio.in_deb_o[N_SW+1]), 32'd1);
    check_output("press_pend", 32'(gpio.irq_pending_o), 32'd0);
    raw_in[N_SW+1] = 1'b0;
    apply_stimulus();
    found = 0; fall_at = 0; pend_at = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      step_cycle();
      if (gpio.in_fall_o[N_SW+1]) fall_at = k;
      if (gpio.irq_pending_o[N_SW+1]) begin found = 1; pend_at = k; end
    end
    check_output("irq_pend_timeout", 32'(found), 32'd1);
    check_output("irq_fall_cycle", 32'(fall_at), 32'(DEB + 2));
    check_output("irq_pend_cycle", 32'(pend_at), 32'(DEB + 3));
    check_output("irq_out", 32'(gpio.irq_o), 32'd1);
    gpio.irq_clr_i[N_SW+1] = 1'b1;
    step_cycle();
    gpio.irq_clr_i = '0;
    check_output("clr_pend", 32'(gpio.irq_pending_o[N_SW+1]), 32'd0);
    check_output("clr_irq",  32'(gpio.irq_o), 32'd0);

    // Clear in the same cycle as a new fall pulse: set wins
    raw_in[N_SW+1] = 1'b1;
    apply_stimulus();
    repeat (10) step_cycle();
    raw_in[N_SW+1] = 1'b0;
    apply_stimulus();
    found = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      step_cycle();
      if (gpio.in_fall_o[N_SW+1]) found = 1;
    end
    check_output("collide_fall_timeout", 32'(found), 32'd1);
    gpio.irq_clr_i[N_SW+1] = 1'b1;
    step_cycle();
    gpio.irq_clr_i = '0;
    check_output("collide_pend", 32'(gpio.irq_pending_o[N_SW+1]), 32'd1);
    step_cycle();
    check_output("collide_hold", 32'(gpio.irq_pending_o[N_SW+1]), 32'd1);
    gpio.irq_clr_i = '1;
    step_cycle();
    gpio.irq_clr_i = '0;

    // Masking: all enables off, toggle every input both ways
    gpio.irq_rise_en_i = '0;
    gpio.irq_fall_en_i = '0;
    rise_seen = '0; fall_seen = '0; irq_seen = 0;
    for (int t = 0; t < 2; t++) begin
      raw_in = ~raw_in;
      apply_stimulus();
      for (int c = 0; c < 10; c++) begin
        step_cycle();
        rise_seen |= gpio.in_rise_o;
        fall_seen |= gpio.in_fall_o;
        irq_seen  |= gpio.irq_o;
      end
    end
    check_output("mask_irq",  32'(irq_seen),  32'd0);
    check_output("mask_rise", 32'(rise_seen), 32'((1 << N_IN) - 1));
    check_output("mask_fall", 32'(fall_seen), 32'((1 << N_IN) - 1));

    // LED PWM table
    foreach (led_table[i]) begin
      gpio.led_i      = led_table[i].led;
      gpio.led_duty_i = led_table[i].duty;
      repeat (3) step_cycle();
      on_cnt = 0; bad_cnt = 0;
      for (int c = 0; c < PERIOD; c++) begin
        step_cycle();
        if (led_o == led_table[i].led) on_cnt++;
        else if (led_o != '0) bad_cnt++;
      end
      check_output("pwm_on_cycles", 32'(on_cnt), 32'(led_table[i].exp_on));
      check_output("pwm_bad_value", 32'(bad_cnt), 32'd0);
    end

    // Reset in the middle of a debounce count on sw[3]
    raw_in = '0;
    apply_stimulus();
    repeat (8) step_cycle();
    gpio.irq_rise_en_i[3] = 1'b1;
    raw_in[3] = 1'b1;
    apply_stimulus();
    repeat (3) step_cycle();
    rst = 1'b1;
    step_cycle();
    check_output("midrst_deb",  32'(gpio.in_deb_o), 32'd0);
    check_output("midrst_rise", 32'(gpio.in_rise_o), 32'd0);
    check_output("midrst_pend", 32'(gpio.irq_pending_o), 32'd0);
    check_output("midrst_irq",  32'(gpio.irq_o), 32'd0);
    check_output("midrst_led",  32'(led_o), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step_cycle();
      check_output("rel_deb",  32'(gpio.in_deb_o[3]),  32'(k >= DEB + 2));
      check_output("rel_rise", 32'(gpio.in_rise_o[3]), 32'(k == DEB + 2));
      check_output("rel_pend", 32'(gpio.irq_pending_o[3]), 32'(k >= DEB + 3));
      check_output("rel_irq",  32'(gpio.irq_o), 32'(k >= DEB + 3));
    end

    // Random phase against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) raw_in[$urandom_range(0, N_IN - 1)] ^= 1'b1;
      apply_stimulus();
      if ($urandom_range(0, 49) == 0) begin
        gpio.irq_rise_en_i = N_IN'($urandom);
        gpio.irq_fall_en_i = N_IN'($urandom);
      end
      gpio.irq_clr_i = ($urandom_range(0, 15) == 0) ? N_IN'($urandom) : '0;
      if ($urandom_range(0, 9) == 0) gpio.led_i = N_LED'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: gpio.led_duty_i = '0;
          1: gpio.led_duty_i = '1;
          default: gpio.led_duty_i = PWM_W'($urandom);
        endcase
      end
      rst = ($urandom_range(0, 399) == 0);
      step_cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
